salu_branch_unit: RTL and testbench

Downstream consumer of the SALU controller's `branch_on_cc` decode. For each SOPP branch issued to the SALU, it evaluates the condition against SCC/VCC/EXEC and computes the target PC. It queues the resolved branch in a small FIFO and hands it to the fetch unit over a valid/ready handshake. Resolved branches leave in issue order, and fetch backpressure reaches the issue side through `issue_ready`.

---
 rtl/salu_branch_unit.sv | 151 +++++++++++++++
 tb/tb_salu_branch_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/salu_branch_unit.sv
// SOPP branch resolver: samples condition operands at issue, resolves taken/target
// one cycle later, and queues the result for the fetch unit in issue order.
module salu_branch_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int WFID_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [WFID_WIDTH-1:0]         issue_wfid,
  input  logic [31:0]                   issue_pc,
  input  logic [15:0]                   issue_simm16,
  input  logic [5:0]                    branch_on_cc,
  input  logic                          scc_value,
  input  logic [63:0]                   vcc_value,
  input  logic [63:0]                   exec_value,
  output logic                          fetch_valid,
  input  logic                          fetch_ready,
  output logic [WFID_WIDTH-1:0]         fetch_wfid,
  output logic                          fetch_taken,
  output logic [31:0]                   fetch_target,
  output logic [$clog2(FIFO_DEPTH):0]   pending_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [WFID_WIDTH-1:0] wfid;
    logic                  taken;
    logic [31:0]           target;
  } entry_t;

  logic                  s1_valid_q, s1_valid_d;
  logic [WFID_WIDTH-1:0] s1_wfid_q,  s1_wfid_d;
  logic [31:0]           s1_pc_q,    s1_pc_d;
  logic [15:0]           s1_simm_q,  s1_simm_d;
  logic [5:0]            s1_cc_q,    s1_cc_d;
  logic                  s1_scc_q,   s1_scc_d;
  logic                  s1_vccz_q,  s1_vccz_d;
  logic                  s1_execz_q, s1_execz_d;

  entry_t                mem_q [FIFO_DEPTH];
  entry_t                mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q,  count_d;

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  s1_taken;
  logic [31:0]           s1_target;
  entry_t                head;

  // Flow control looks only at registered state, so the issue side never
  // depends combinationally on fetch_ready.
  always_comb begin
    pending_count = count_q + CW'(s1_valid_q);
    issue_ready   = (pending_count < CW'(FIFO_DEPTH));
    accept        = issue_valid & issue_ready & (branch_on_cc != 6'd0);
  end

  always_comb begin
    s1_valid_d = accept;
    s1_wfid_d  = s1_wfid_q;
    s1_pc_d    = s1_pc_q;
    s1_simm_d  = s1_simm_q;
    s1_cc_d    = s1_cc_q;
    s1_scc_d   = s1_scc_q;
    s1_vccz_d  = s1_vccz_q;
    s1_execz_d = s1_execz_q;
    if (accept) begin
      s1_wfid_d  = issue_wfid;
      s1_pc_d    = issue_pc;
      s1_simm_d  = issue_simm16;
      s1_cc_d    = branch_on_cc;
      s1_scc_d   = scc_value;
      s1_vccz_d  = (vcc_value == 64'd0);
      s1_execz_d = (exec_value == 64'd0);
    end
  end

  always_comb begin
    s1_taken  = (s1_cc_q == 6'h3F)
              | (s1_cc_q[0] & ~s1_scc_q)
              | (s1_cc_q[1] &  s1_scc_q)
              | (s1_cc_q[2] &  s1_vccz_q)
              | (s1_cc_q[3] & ~s1_vccz_q)
              | (s1_cc_q[4] &  s1_execz_q)
              | (s1_cc_q[5] & ~s1_execz_q);
    s1_target = s1_pc_q + 32'd4
              + (s1_taken ? {{14{s1_simm_q[15]}}, s1_simm_q, 2'b00} : 32'd0);
  end

  always_comb begin
    fetch_valid = (count_q != '0);
    push        = s1_valid_q;
    pop         = fetch_valid & fetch_ready;

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q].wfid   = s1_wfid_q;
      mem_d[wr_ptr_q].taken  = s1_taken;
      mem_d[wr_ptr_q].target = s1_target;
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    head         = mem_q[rd_ptr_q];
    fetch_wfid   = head.wfid;
    fetch_taken  = head.taken;
    fetch_target = head.target;
  end

  // Storage is cleared on reset so the head outputs read as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_wfid_q  <= '0;
      s1_pc_q    <= '0;
      s1_simm_q  <= '0;
      s1_cc_q    <= '0;
      s1_scc_q   <= 1'b0;
      s1_vccz_q  <= 1'b0;
      s1_execz_q <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_wfid_q  <= s1_wfid_d;
      s1_pc_q    <= s1_pc_d;
      s1_simm_q  <= s1_simm_d;
      s1_cc_q    <= s1_cc_d;
      s1_scc_q   <= s1_scc_d;
      s1_vccz_q  <= s1_vccz_d;
      s1_execz_q <= s1_execz_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_salu_branch_unit.sv
// Scoreboard bench for salu_branch_unit: a negedge monitor predicts each
// resolved branch from the issue-cycle operands and checks it on pop.
module tb_salu_branch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [5:0]  issue_wfid = '0;
  logic [31:0] issue_pc = '0;
  logic [15:0] issue_simm16 = '0;
  logic [5:0]  branch_on_cc = '0;
  logic        scc_value = 1'b0;
  logic [63:0] vcc_value = '0;
  logic [63:0] exec_value = '0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [5:0]  fetch_wfid;
  logic        fetch_taken;
  logic [31:0] fetch_target;
  logic [2:0]  pending_count;

  salu_branch_unit #(.FIFO_DEPTH(DEPTH), .WFID_WIDTH(6)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_wfid(issue_wfid), .issue_pc(issue_pc), .issue_simm16(issue_simm16),
    .branch_on_cc(branch_on_cc), .scc_value(scc_value),
    .vcc_value(vcc_value), .exec_value(exec_value),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_wfid(fetch_wfid), .fetch_taken(fetch_taken),
    .fetch_target(fetch_target), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [5:0]  wfid;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  function automatic exp_t model(input logic [5:0] w, input logic [31:0] pc,
                                 input logic [15:0] simm, input logic [5:0] cc,
                                 input logic scc, input logic [63:0] vcc,
                                 input logic [63:0] exec);
    exp_t m;
    bit   vz, ez;
    int   off;
    vz  = (vcc == 64'd0);
    ez  = (exec == 64'd0);
    off = 4 * int'($signed(simm));
    m.wfid = w;
    if (cc == 6'h3F) m.taken = 1'b1;
    else m.taken = (cc[0] && !scc) || (cc[1] && scc) || (cc[2] && vz) ||
                   (cc[3] && !vz) || (cc[4] && ez) || (cc[5] && !ez);
    m.target = m.taken ? pc + 32'(4 + off) : pc + 32'd4;
    return m;
  endfunction

  // Scoreboard: queue holds every accepted branch not yet popped (S1 + FIFO).
  exp_t sbq[$];
  bit   s1_pend = 0;

  always @(negedge clk) begin
    exp_t e;
    int   sz;
    bit   acc;
    if (rst) begin
      sbq.delete();
      s1_pend = 0;
    end else begin
      sz = sbq.size();
      chk("pending_count", 64'(pending_count), 64'(sz));
      chk("issue_ready", 64'(issue_ready), 64'(sz < DEPTH));
      chk("fetch_valid", 64'(fetch_valid), 64'(sz > (s1_pend ? 1 : 0)));
      if (fetch_valid && fetch_ready) begin
        if (sbq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL pop_unexpected: got wfid 0x%0h, expected no entry", fetch_wfid);
        end else begin
          e = sbq.pop_front();
          chk("pop_wfid", 64'(fetch_wfid), 64'(e.wfid));
          chk("pop_taken", 64'(fetch_taken), 64'(e.taken));
          chk("pop_target", 64'(fetch_target), 64'(e.target));
        end
      end
      acc = issue_valid && (sz < DEPTH) && (branch_on_cc != 6'd0);
      if (acc) sbq.push_back(model(issue_wfid, issue_pc, issue_simm16, branch_on_cc,
                                   scc_value, vcc_value, exec_value));
      s1_pend = acc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present one branch and hold it until accepted (bounded).
  task automatic issue1(input logic [5:0] w, input logic [31:0] pc, input logic [15:0] simm,
                        input logic [5:0] cc, input logic scc, input logic [63:0] vcc,
                        input logic [63:0] exec);
    bit ok = 0;
    issue_valid = 1'b1; issue_wfid = w; issue_pc = pc; issue_simm16 = simm;
    branch_on_cc = cc; scc_value = scc; vcc_value = vcc; exec_value = exec;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = issue_ready;
      step();
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL issue_accept: got issue_ready=0, expected 1 within 20 cycles");
    end
    issue_valid = 1'b0;
  endtask

  // Wait for the head, compare against literal expectations, then pop it.
  task automatic expect_head(input string name, input logic [5:0] w,
                             input logic t, input logic [31:0] tgt);
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = fetch_valid;
      if (!seen) step();
    end
    chk({name, "_valid"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({name, "_wfid"}, 64'(fetch_wfid), 64'(w));
      chk({name, "_taken"}, 64'(fetch_taken), 64'(t));
      chk({name, "_target"}, 64'(fetch_target), 64'(tgt));
    end
    step();
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
  endtask

  task automatic rand_inputs(input bit force_valid);
    logic [5:0] ccs [8];
    ccs = '{6'h00, 6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h3F};
    issue_valid  = force_valid ? 1'b1 : 1'($urandom_range(0, 1));
    issue_wfid   = 6'($urandom);
    issue_pc     = $urandom;
    issue_simm16 = 16'($urandom);
    branch_on_cc = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ccs[$urandom_range(0, 7)];
    scc_value    = 1'($urandom);
    vcc_value    = ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom};
    exec_value   = ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom};
  endtask

  initial begin
    int accepted;
    int pops;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    chk("rst_fetch_wfid", 64'(fetch_wfid), 64'd0);
    chk("rst_fetch_taken", 64'(fetch_taken), 64'd0);
    chk("rst_fetch_target", 64'(fetch_target), 64'd0);
    chk("rst_pending", 64'(pending_count), 64'd0);
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    step();

    issue1(6'd5, 32'h100, 16'h0003, 6'h3F, 1'b0, 64'd1, 64'd1);
    expect_head("uncond", 6'd5, 1'b1, 32'h110);
    issue1(6'd6, 32'h200, 16'h0010, 6'h01, 1'b1, 64'd1, 64'd1);
    expect_head("scc0_false", 6'd6, 1'b0, 32'h204);
    issue1(6'd7, 32'h300, 16'h0010, 6'h04, 1'b0, 64'd0, 64'd1);
    expect_head("vccz_true", 6'd7, 1'b1, 32'h344);
    issue1(6'd8, 32'h400, 16'h0008, 6'h20, 1'b0, 64'd1, 64'd0);
    expect_head("execnz_false", 6'd8, 1'b0, 32'h404);
    issue1(6'd9, 32'h0, 16'hFFFE, 6'h3F, 1'b0, 64'd1, 64'd1);
    expect_head("wrap", 6'd9, 1'b1, 32'hFFFF_FFFC);

    // Non-branch is ignored; scc change after accept must not matter.
    issue_valid = 1'b1; branch_on_cc = 6'h00;
    step();
    issue_valid = 1'b0;
    step();
    @(negedge clk);
    chk("nonbranch_pending", 64'(pending_count), 64'd0);
    step();
    issue1(6'd10, 32'h500, 16'h0001, 6'h01, 1'b0, 64'd1, 64'd1);
    scc_value = 1'b1;
    expect_head("scc_sampled", 6'd10, 1'b1, 32'h508);

    // Backpressure to full.
    accepted = 0;
    fetch_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue_valid = 1'b1; branch_on_cc = 6'h3F; issue_wfid = 6'(i);
      issue_pc = 32'h1000 + 32'(i * 16); issue_simm16 = 16'(i);
      @(negedge clk);
      if (issue_ready) accepted++;
      step();
    end
    issue_valid = 1'b0;
    @(negedge clk);
    chk("full_accepted", 64'(accepted), 64'(DEPTH));
    chk("full_issue_ready", 64'(issue_ready), 64'd0);
    chk("full_pending", 64'(pending_count), 64'(DEPTH));
    step();
    fetch_ready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    chk("drained_pending", 64'(pending_count), 64'd0);
    step();

    // Full with simultaneous push/pop across several pointer laps.
    fetch_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) issue1(6'(20 + i), 32'h2000 + 32'(i * 4), 16'h0, 6'h3F, 1'b0, 64'd1, 64'd1);
    pops = 0;
    fetch_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rand_inputs(1'b1);
      @(negedge clk);
      if (fetch_valid) pops++;
      step();
    end
    issue_valid = 1'b0;
    n_checks++;
    if (pops < 3 * DEPTH) begin
      n_fail++;
      $display("FAIL pushpop_pops: got %0d, expected >= %0d", pops, 3 * DEPTH);
    end
    repeat (6) step();

    // Mid-operation reset with 3 queued plus S1 valid.
    fetch_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue1(6'(30 + i), 32'h3000 + 32'(i * 4), 16'h1, 6'h3F, 1'b0, 64'd1, 64'd1);
    rst = 1'b1;
    issue_valid = 1'b1; branch_on_cc = 6'h3F;
    step();
    rst = 1'b0;
    issue_valid = 1'b0;
    @(negedge clk);
    chk("midrst_fetch_valid", 64'(fetch_valid), 64'd0);
    chk("midrst_pending", 64'(pending_count), 64'd0);
    chk("midrst_issue_ready", 64'(issue_ready), 64'd1);
    step();
    issue1(6'd40, 32'h4000, 16'hFFFF, 6'h3F, 1'b0, 64'd1, 64'd1);
    expect_head("post_rst", 6'd40, 1'b1, 32'h4000);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rand_inputs(1'b0);
      fetch_ready = 1'($urandom_range(0, 3) != 0);
      step();
    end
    issue_valid = 1'b0;
    fetch_ready = 1'b1;
    repeat (10) step();
    @(negedge clk);
    chk("final_pending", 64'(pending_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
